// File: rtl/cpubus_pkg.sv
// Shared phase map, widths and request-FSM state type for the byte-serial CPU bus
// responder.
package cpubus_pkg;

  localparam int PH_W  = 5;
  localparam int BYTES = 8;

  localparam logic [PH_W-1:0] PH_ADDR_FIRST = 5'd1;
  localparam logic [PH_W-1:0] PH_ADDR_LAST  = 5'd8;
  localparam logic [PH_W-1:0] PH_FLAG       = 5'd9;
  localparam logic [PH_W-1:0] PH_RD_FIRST   = 5'd10;
  localparam logic [PH_W-1:0] PH_RD_LAST    = 5'd17;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } req_state_t;

endpackage

// File: rtl/cpu_bus_responder_if.sv
// Host byte lanes, memory valid/ack port and error flag of the CPU bus responder.
interface cpu_bus_responder_if;

  logic [7:0]  host_ao;
  logic [7:0]  host_d_in;
  logic [7:0]  host_d_out;
  logic        host_d_oe;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        frame_done;
  logic        err;
  logic        err_clr;

  modport slave (
    input  host_ao, host_d_in, mem_ack, mem_rdata, err_clr,
    output host_d_out, host_d_oe, mem_req, mem_we, mem_addr, mem_wdata,
           frame_done, err
  );

  modport master (
    output host_ao, host_d_in, mem_ack, mem_rdata, err_clr,
    input  host_d_out, host_d_oe, mem_req, mem_we, mem_addr, mem_wdata,
           frame_done, err
  );

endinterface

// File: rtl/cpubus_phase_ctr.sv
// Free-running frame phase counter, kept in lockstep with the host's own count.
// o_wrap is a registered pulse produced by the edge that leaves the last phase.
module cpubus_phase_ctr
  import cpubus_pkg::*;
#(
  parameter int LAST_PH = 17
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PH_W-1:0] o_ph,
  output logic            o_wrap
);

  logic [PH_W-1:0] r_ph;
  logic            r_wrap;
  logic            w_last;

  assign w_last = (r_ph == PH_W'(LAST_PH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ph   <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_last;
      r_ph   <= w_last ? '0 : r_ph + 1'b1;
    end
  end

  assign o_ph   = r_ph;
  assign o_wrap = r_wrap;

endmodule

// File: rtl/cpu_bus_responder.sv
// Target end of the byte-serial CPU bus: deserialises address/data/flag per frame,
// runs a speculative read plus an optional write, and returns read data MSB-first.
module cpu_bus_responder
  import cpubus_pkg::*;
#(
  parameter int         LAST_PH   = 17,
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input logic                clk,
  input logic                rst_n,
  cpu_bus_responder_if.slave bus
);

  logic [PH_W-1:0] w_ph;
  logic            w_wrap;

  logic [63:0] r_addr, r_wdata, r_rbuf, r_maddr, r_mwdata;
  logic        r_wr, r_late, r_err, r_we, r_wpend, r_rdwait;
  req_state_t  r_state, w_state_nxt;

  logic [63:0] w_maddr_nxt, w_mwdata_nxt;
  logic        w_we_nxt, w_wpend_nxt, w_rdwait_nxt;
  logic        w_ph8, w_ph9, w_ack_rd, w_flag_wr, w_rd_ontime, w_d_oe;
  logic [2:0]  w_sel;
  logic [7:0]  w_d_out;

  cpubus_phase_ctr #(.LAST_PH(LAST_PH)) u_phase_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_ph   (w_ph),
    .o_wrap (w_wrap)
  );

  assign w_ph8       = (w_ph == PH_ADDR_LAST);
  assign w_ph9       = (w_ph == PH_FLAG);
  assign w_ack_rd    = (r_state == ST_REQ) && !r_we && bus.mem_ack;
  assign w_rd_ontime = w_ph9 && w_ack_rd;
  assign w_flag_wr   = w_ph9 && bus.host_ao[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rbuf  <= '0;
      r_wr    <= 1'b0;
      r_late  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      for (int k = 1; k <= BYTES; k++) begin
        if (int'(w_ph) == k) begin
          r_addr[8*k-1 -: 8]  <= bus.host_ao;
          r_wdata[8*k-1 -: 8] <= bus.host_d_in;
        end
      end
      // Read data only counts if it lands in the flag phase; later acks are dropped.
      if (w_ph9) begin
        r_wr   <= bus.host_ao[0];
        r_late <= !w_rd_ontime;
        if (w_rd_ontime) begin
          r_rbuf <= bus.mem_rdata;
        end
      end
      r_err <= (w_ph9 && !w_rd_ontime) ? 1'b1 : (bus.err_clr ? 1'b0 : r_err);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_we     <= 1'b0;
      r_maddr  <= '0;
      r_mwdata <= '0;
      r_wpend  <= 1'b0;
      r_rdwait <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_we     <= w_we_nxt;
      r_maddr  <= w_maddr_nxt;
      r_mwdata <= w_mwdata_nxt;
      r_wpend  <= w_wpend_nxt;
      r_rdwait <= w_rdwait_nxt;
    end
  end

  // Address and write data are locked at read issue, so the write that follows reuses
  // them even if the host has started shifting the next frame.
  always_comb begin
    w_state_nxt  = r_state;
    w_we_nxt     = r_we;
    w_maddr_nxt  = r_maddr;
    w_mwdata_nxt = r_mwdata;
    w_wpend_nxt  = r_wpend || w_flag_wr;
    w_rdwait_nxt = r_rdwait;
    case (r_state)
      ST_IDLE: begin
        if (w_ph8) begin
          w_state_nxt  = ST_REQ;
          w_we_nxt     = 1'b0;
          w_maddr_nxt  = {bus.host_ao, r_addr[55:0]};
          w_mwdata_nxt = {bus.host_d_in, r_wdata[55:0]};
          w_rdwait_nxt = 1'b0;
        end else if (r_rdwait) begin
          w_state_nxt  = ST_REQ;
          w_we_nxt     = 1'b0;
          w_maddr_nxt  = r_addr;
          w_mwdata_nxt = r_wdata;
          w_rdwait_nxt = 1'b0;
        end else if (r_wpend) begin
          w_state_nxt = ST_REQ;
          w_we_nxt    = 1'b1;
          w_wpend_nxt = 1'b0;
        end
      end
      ST_REQ: begin
        if (w_ph8) begin
          w_rdwait_nxt = 1'b1;
        end
        if (bus.mem_ack) begin
          if (!r_we && (r_wpend || w_flag_wr)) begin
            w_we_nxt    = 1'b1;
            w_wpend_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Return lane: phase 10 carries the top byte, phase 17 the bottom byte.
  always_comb begin
    w_d_oe  = !r_wr && (w_ph >= PH_RD_FIRST) && (w_ph <= PH_RD_LAST);
    w_sel   = 3'(PH_RD_LAST - w_ph);
    w_d_out = 8'h00;
    if (w_d_oe) begin
      w_d_out = r_late ? FILL_BYTE : r_rbuf[{w_sel, 3'b000} +: 8];
    end
  end

  assign bus.host_d_out = w_d_out;
  assign bus.host_d_oe  = w_d_oe;
  assign bus.mem_req    = (r_state == ST_REQ);
  assign bus.mem_we     = r_we;
  assign bus.mem_addr   = r_maddr;
  assign bus.mem_wdata  = r_mwdata;
  assign bus.frame_done = w_wrap;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Frame-level bench for cpu_bus_responder: plays the host lanes and the memory,
// with expected memory transactions held in a scoreboard queue.
module tb_cpu_bus_responder;

  typedef struct {
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_bus_responder_if bus();

  cpu_bus_responder #(.LAST_PH(17), .FILL_BYTE(8'hFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  txn_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  logic exp_err = 1'b0;
  bit   first_frame = 1'b1;

  // One host frame from phase 0; masks select per phase where ack / err_clr are driven.
  task automatic run_frame(input logic [63:0] addr, input logic [63:0] wdata,
                           input bit flag, input logic [63:0] rdata,
                           input logic [17:0] ack_mask, input logic [17:0] clr_mask,
                           input bit late, input int stop_ph);
    txn_t       t;
    bit         prev_ack;
    bit         exp_oe;
    logic [7:0] exp_out;
    sb_q.push_back('{1'b0, addr, wdata});
    if (flag) sb_q.push_back('{1'b1, addr, wdata});
    bus.mem_rdata = rdata;
    prev_ack = 1'b0;
    for (int p = 0; p < stop_ph; p++) begin
      @(negedge clk);
      exp_oe  = !flag && (p >= 10) && (p <= 17);
      exp_out = exp_oe ? (late ? 8'hFF : rdata[8*(17-p) +: 8]) : 8'h00;
      total++;
      if (bus.host_d_oe !== exp_oe) begin
        bad++;
        $display("[TB] FAIL host_d_oe ph=%0d got=%b exp=%b", p, bus.host_d_oe, exp_oe);
      end
      total++;
      if (bus.host_d_out !== exp_out) begin
        bad++;
        $display("[TB] FAIL host_d_out ph=%0d got=%h exp=%h", p, bus.host_d_out, exp_out);
      end
      total++;
      if (bus.err !== exp_err) begin
        bad++;
        $display("[TB] FAIL err ph=%0d got=%b exp=%b", p, bus.err, exp_err);
      end
      total++;
      if (bus.frame_done !== (p == 0 && !first_frame)) begin
        bad++;
        $display("[TB] FAIL frame_done ph=%0d got=%b exp=%b", p, bus.frame_done,
                 (p == 0 && !first_frame));
      end
      if (prev_ack && sb_q.size() == 0) begin
        total++;
        if (bus.mem_req !== 1'b0) begin
          bad++;
          $display("[TB] FAIL req_drop ph=%0d got=%b exp=0", p, bus.mem_req);
        end
      end
      prev_ack = 1'b0;
      if (bus.mem_req === 1'b1 && ack_mask[p]) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_req ph=%0d got we=%b addr=%h exp=none", p,
                   bus.mem_we, bus.mem_addr);
        end else begin
          t = sb_q.pop_front();
          if (bus.mem_we !== t.we || bus.mem_addr !== t.addr ||
              (t.we && bus.mem_wdata !== t.wdata)) begin
            bad++;
            $display("[TB] FAIL mem_txn ph=%0d got we=%b addr=%h wdata=%h exp we=%b addr=%h wdata=%h",
                     p, bus.mem_we, bus.mem_addr, bus.mem_wdata, t.we, t.addr, t.wdata);
          end
        end
        prev_ack = 1'b1;
        bus.mem_ack = 1'b1;
      end else begin
        bus.mem_ack = 1'b0;
      end
      bus.host_ao   = (p >= 1 && p <= 8) ? addr[8*(p-1) +: 8] :
                      (p == 9) ? {7'b1010101, flag} : 8'h00;
      bus.host_d_in = (p >= 1 && p <= 8) ? wdata[8*(p-1) +: 8] : 8'h00;
      bus.err_clr   = clr_mask[p];
      if (p == 9 && late) exp_err = 1'b1;
      else if (clr_mask[p]) exp_err = 1'b0;
    end
    first_frame = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    total++;
    if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.host_d_oe !== 1'b0 ||
        bus.host_d_out !== 8'h00 || bus.frame_done !== 1'b0 || bus.err !== 1'b0 ||
        bus.mem_addr !== 64'h0 || bus.mem_wdata !== 64'h0) begin
      bad++;
      $display("[TB] FAIL %s got req=%b we=%b oe=%b out=%h fd=%b err=%b addr=%h wdata=%h exp all zero",
               tag, bus.mem_req, bus.mem_we, bus.host_d_oe, bus.host_d_out,
               bus.frame_done, bus.err, bus.mem_addr, bus.mem_wdata);
    end
  endtask

  task automatic check_sb_empty(input string tag);
    total++;
    if (sb_q.size() !== 0) begin
      bad++;
      $display("[TB] FAIL %s pending_txns got=%0d exp=0", tag, sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.host_ao = 8'h00;
    bus.host_d_in = 8'h00;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 64'h0;
    bus.err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("reset_held");
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_idle_outputs("reset_released");
  endtask

  task automatic test_write_frame();
    run_frame(64'h0706050403020100, 64'h1122334455667788, 1'b1, 64'hDEADBEEF00000000,
              18'h3FE00, 18'h0, 1'b0, 18);
    check_sb_empty("write_frame");
  endtask

  task automatic test_read_frame();
    run_frame(64'h0000_1000_2000_3000, 64'h0, 1'b0, 64'hA1A2A3A4A5A6A7A8,
              18'h3FE00, 18'h0, 1'b0, 18);
    check_sb_empty("read_frame");
  endtask

  task automatic test_late_read();
    run_frame(64'hCAFE_0000_0000_0040, 64'h0, 1'b0, 64'h0102030405060708,
              18'h3F800, 18'h0, 1'b1, 18);
    check_sb_empty("late_read");
  endtask

  task automatic test_slow_write();
    run_frame(64'h0000_0000_0000_0100, 64'h5555_AAAA_5555_AAAA, 1'b1, 64'h0,
              18'h00200, 18'h0, 1'b0, 18);
    run_frame(64'h0000_0000_0000_0200, 64'h0, 1'b0, 64'h1111111111111111,
              18'h3FC00, 18'h0, 1'b1, 18);
    check_sb_empty("slow_write");
  endtask

  task automatic test_err_clr();
    run_frame(64'h0000_0000_0000_0300, 64'h0, 1'b0, 64'h2222222222222222,
              18'h3F800, 18'h00600, 1'b1, 18);
    check_sb_empty("err_clr");
  endtask

  task automatic test_reset_mid_frame();
    run_frame(64'h0000_0000_0000_0400, 64'h0, 1'b0, 64'h0, 18'h0, 18'h0, 1'b1, 18);
    run_frame(64'h0000_0000_0000_0500, 64'h0, 1'b0, 64'h0, 18'h0, 18'h0, 1'b1, 5);
    @(negedge clk);
    total++;
    if (bus.mem_req !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pre_reset_req got=%b exp=1", bus.mem_req);
    end
    rst_n = 1'b0;
    bus.mem_ack = 1'b0;
    bus.host_ao = 8'h00;
    bus.host_d_in = 8'h00;
    bus.err_clr = 1'b0;
    #1 check_idle_outputs("mid_frame_reset");
    sb_q.delete();
    exp_err = 1'b0;
    first_frame = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame(64'h8877665544332211, 64'h0, 1'b0, 64'hB1B2B3B4B5B6B7B8,
              18'h3FE00, 18'h0, 1'b0, 18);
    check_sb_empty("after_reset_frame");
  endtask

  initial begin
    test_reset();
    test_write_frame();
    test_read_frame();
    test_late_read();
    test_slow_write();
    test_err_clr();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
